// File: rtl/mp_adder_seq_if.sv
// Request/response bundle for the sequential multi-precision adder.
// Handshake: the requester raises start for one cycle with subtract/in_a/in_b
// valid in that cycle; the adder accepts it only when not busy (IDLE or DONE),
// drives busy while chunks are processed, and pulses done for one cycle when
// result is valid. There is no back-pressure; a start seen while busy is dropped.
interface mp_adder_seq_if #(
  parameter int IN_WIDTH = 1024
) ();
  logic                start;
  logic                subtract;
  logic [IN_WIDTH-1:0] in_a;
  logic [IN_WIDTH-1:0] in_b;
  logic [IN_WIDTH:0]   result;
  logic                busy;
  logic                done;
  logic [1:0]          dbg_state;

  modport master (
    output start, subtract, in_a, in_b,
    input  result, busy, done, dbg_state
  );

  modport slave (
    input  start, subtract, in_a, in_b,
    output result, busy, done, dbg_state
  );
endinterface

// File: rtl/mp_adder_seq.sv
// Sequential multi-precision adder/subtractor. Operands are consumed one
// ADDER_WIDTH chunk per cycle, LSB first, keeping the carry chain short.
// Subtraction is A + ~B + 1, so the final carry is the no-borrow flag.
// IN_WIDTH must be a multiple of ADDER_WIDTH and larger than it.
module mp_adder_seq #(
  parameter int IN_WIDTH    = 1024,
  parameter int ADDER_WIDTH = 256
) (
  input  logic            clk,
  input  logic            resetn,   // active-high asynchronous reset
  mp_adder_seq_if.slave   bus
);

  localparam int N_CHUNKS = IN_WIDTH / ADDER_WIDTH;
  localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IN_WIDTH-1:0]    a_q, a_d;
  logic [IN_WIDTH-1:0]    b_q, b_d;
  logic [IN_WIDTH:0]      result_q, result_d;
  logic                   carry_q, carry_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ADDER_WIDTH:0]   chunk;

  // One chunk of the addition: low slices of the shifting operands plus carry.
  always_comb begin
    chunk = {1'b0, a_q[ADDER_WIDTH-1:0]} + {1'b0, b_q[ADDER_WIDTH-1:0]}
          + {{ADDER_WIDTH{1'b0}}, carry_q};
  end

  // Next-state logic: load on accepted start, shift one chunk per RUN cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_RUN: begin
        // New chunk enters at the top; after N_CHUNKS shifts the low bits
        // hold the full result and the top bit the final carry.
        result_d = {chunk[ADDER_WIDTH], chunk[ADDER_WIDTH-1:0],
                    result_q[IN_WIDTH-1:ADDER_WIDTH]};
        carry_d  = chunk[ADDER_WIDTH];
        a_d      = a_q >> ADDER_WIDTH;
        b_d      = b_q >> ADDER_WIDTH;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N_CHUNKS - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.in_a;
          b_d     = bus.subtract ? ~bus.in_b : bus.in_b;
          carry_d = bus.subtract;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any job without a done pulse.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Bench for mp_adder_seq: a small 8/4 instance for directed timing cases and
// a default 1024/256 instance for random vectors against an arithmetic model.
module tb_mp_adder_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_l;

  mp_adder_seq_if #(.IN_WIDTH(8))    bus_s ();
  mp_adder_seq_if #(.IN_WIDTH(1024)) bus_l ();

  mp_adder_seq #(.IN_WIDTH(8), .ADDER_WIDTH(4)) dut_s (
    .clk    (clk),
    .resetn (rst_s),
    .bus    (bus_s.slave)
  );

  mp_adder_seq dut_l (
    .clk    (clk),
    .resetn (rst_l),
    .bus    (bus_l.slave)
  );

  localparam int NS = 2;  // chunks in the small instance
  localparam int NL = 4;  // chunks in the large instance

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [1024:0] exp_q[$];

  task automatic check(input string tag, input logic [1024:0] obs,
                       input logic [1024:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h_..%0h expected=%0h_..%0h", tag,
             obs[1024:1023], obs[191:0], exp[1024:1023], exp[191:0]);
    end
  endtask

  // Reference models: plain arithmetic on whole operands.
  function automatic logic [8:0] ref_small(input logic [7:0] a, input logic [7:0] b,
                                           input logic sub);
    logic [7:0] diff;
    if (sub) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [1024:0] ref_large(input logic [1023:0] a,
                                              input logic [1023:0] b, input logic sub);
    logic [1023:0] diff;
    if (sub) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  // ---------------- driver tasks ----------------
  // Pulse start across one rising edge; returns at the falling edge after it,
  // with operands scrambled so late changes would show up in the result.
  task automatic start_s(input logic [7:0] a, input logic [7:0] b, input logic sub);
    @(negedge clk);
    bus_s.start = 1'b1; bus_s.in_a = a; bus_s.in_b = b; bus_s.subtract = sub;
    @(negedge clk);
    bus_s.start = 1'b0;
    bus_s.in_a = 8'($urandom); bus_s.in_b = 8'($urandom); bus_s.subtract = ~sub;
  endtask

  task automatic start_l(input logic [1023:0] a, input logic [1023:0] b, input logic sub);
    @(negedge clk);
    bus_l.start = 1'b1; bus_l.in_a = a; bus_l.in_b = b; bus_l.subtract = sub;
    @(negedge clk);
    bus_l.start = 1'b0;
    for (int j = 0; j < 32; j++) begin
      bus_l.in_a[j*32 +: 32] = $urandom;
      bus_l.in_b[j*32 +: 32] = $urandom;
    end
  endtask

  // Counts falling edges until done; -1 if it never comes.
  task automatic wait_done_s(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_s.done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic wait_done_l(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_l.done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic job_s(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sub);
    int lat;
    exp_q.push_back(1025'(ref_small(a, b, sub)));
    start_s(a, b, sub);
    check({tag, "_busy"}, 1025'(bus_s.busy), 1025'(1));
    wait_done_s(lat);
    check({tag, "_lat"}, 1025'(lat), 1025'(NS));
    check({tag, "_res"}, 1025'(bus_s.result), exp_q.pop_front());
  endtask

  task automatic job_l(input string tag, input logic [1023:0] a, input logic [1023:0] b,
                       input logic sub);
    int lat;
    exp_q.push_back(ref_large(a, b, sub));
    start_l(a, b, sub);
    wait_done_l(lat);
    check({tag, "_lat"}, 1025'(lat), 1025'(NL));
    check({tag, "_res"}, bus_l.result, exp_q.pop_front());
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    int n_done;
    logic [1023:0] ra, rb;
    logic rsub;

    bus_s.start = 1'b0; bus_s.subtract = 1'b0; bus_s.in_a = '0; bus_s.in_b = '0;
    bus_l.start = 1'b0; bus_l.subtract = 1'b0; bus_l.in_a = '0; bus_l.in_b = '0;
    rst_s = 1'b1; rst_l = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_result", 1025'(bus_s.result), '0);
    check("rst_busy",   1025'(bus_s.busy),   '0);
    check("rst_done",   1025'(bus_s.done),   '0);
    check("rst_result_l", bus_l.result, '0);
    rst_s = 1'b0; rst_l = 1'b0;

    // Add with full carry propagation; busy spans both chunk edges.
    start_s(8'hFF, 8'h01, 1'b0);
    check("add_busy0", 1025'(bus_s.busy), 1025'(1));
    @(negedge clk);
    check("add_busy1", 1025'(bus_s.busy), 1025'(1));
    check("add_nodone", 1025'(bus_s.done), 1025'(0));
    @(negedge clk);
    check("add_done", 1025'(bus_s.done), 1025'(1));
    check("add_busy_off", 1025'(bus_s.busy), 1025'(0));
    check("add_res", 1025'(bus_s.result), 1025'(9'h100));
    @(negedge clk);
    check("add_done_pulse", 1025'(bus_s.done), 1025'(0));
    check("add_res_hold", 1025'(bus_s.result), 1025'(9'h100));

    job_s("sub_eq", 8'h35, 8'h35, 1'b1);
    check("sub_eq_const", 1025'(bus_s.result), 1025'(9'h100));
    job_s("sub_borrow", 8'h00, 8'h01, 1'b1);
    check("sub_borrow_const", 1025'(bus_s.result), 1025'(9'h0FF));

    // Start re-pulsed during RUN must be dropped.
    start_s(8'h1A, 8'h2B, 1'b0);
    bus_s.start = 1'b1; bus_s.in_a = 8'h77; bus_s.in_b = 8'h11; bus_s.subtract = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    @(negedge clk);
    check("ign_done", 1025'(bus_s.done), 1025'(1));
    check("ign_res", 1025'(bus_s.result), 1025'(9'h045));
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_s.done === 1'b1) n_done++;
    end
    check("ign_single_done", 1025'(n_done), 1025'(0));

    // Back-to-back: new start issued in the DONE cycle.
    start_s(8'h12, 8'h34, 1'b0);
    wait_done_s(lat);
    check("b2b_lat1", 1025'(lat), 1025'(NS));
    check("b2b_res1", 1025'(bus_s.result), 1025'(ref_small(8'h12, 8'h34, 1'b0)));
    bus_s.start = 1'b1; bus_s.in_a = 8'h80; bus_s.in_b = 8'h80; bus_s.subtract = 1'b0;
    @(negedge clk);
    bus_s.start = 1'b0;
    check("b2b_busy", 1025'(bus_s.busy), 1025'(1));
    check("b2b_done_off", 1025'(bus_s.done), 1025'(0));
    wait_done_s(lat);
    check("b2b_lat2", 1025'(lat), 1025'(NS));
    check("b2b_res2", 1025'(bus_s.result), 1025'(9'h100));

    // Random small vectors.
    for (int v = 0; v < 20; v++)
      job_s("rnd_s", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Reset after one chunk: immediate clear, no done afterwards.
    start_s(8'hAB, 8'hCD, 1'b0);
    @(negedge clk);
    rst_s = 1'b1;
    #1;
    check("mid_rst_result", 1025'(bus_s.result), '0);
    check("mid_rst_busy",   1025'(bus_s.busy),   '0);
    check("mid_rst_done",   1025'(bus_s.done),   '0);
    @(negedge clk);
    rst_s = 1'b0;
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_s.done === 1'b1) n_done++;
    end
    check("mid_rst_nodone", 1025'(n_done), 1025'(0));
    check("mid_rst_busy2", 1025'(bus_s.busy), '0);

    // Large instance: boundaries, then random vectors.
    job_l("l_ones_add", {1024{1'b1}}, {1024{1'b1}}, 1'b0);
    ra = '1;
    check("l_ones_msb", 1025'(bus_l.result[1024]), 1025'(1));
    for (int j = 0; j < 32; j++) ra[j*32 +: 32] = $urandom;
    job_l("l_sub_eq", ra, ra, 1'b1);
    check("l_sub_eq_const", bus_l.result, {1'b1, 1024'b0});
    job_l("l_sub_borrow", '0, 1024'd1, 1'b1);
    check("l_sub_borrow_const", bus_l.result, {1'b0, {1024{1'b1}}});

    for (int v = 0; v < 200; v++) begin
      for (int j = 0; j < 32; j++) begin
        ra[j*32 +: 32] = $urandom;
        rb[j*32 +: 32] = $urandom;
      end
      rsub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rb = ra;
      job_l("rnd_l", ra, rb, rsub);
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
